line_buffer_ctrl: RTL and testbench
===================================

// Module: line_buffer_ctrl
// PURPOSE
// Sequencer for the two-bank ping-pong pixel line buffer in the ADC->readout path.
// Generates bank select, write/read enables and read-counter restart so one bank fills
// from the ADC while the other drains to readout. Tracks bank occupancy, drops lines on
// overflow and indexes rows within a frame. Single clock; integration ties buffer CLK1=CLK2=CLK.
// PARAMETERS
// PIX_IN_ROW  640  pixels per line; length of every fill and drain burst
// ROWS        480  lines per frame; ROW_IDX wraps at this value
// PORTS
// CLK          in   1   clock, all logic on posedge
// RESET        in   1   reset, asynchronous, active-high
// FRAME_SYNC   in   1   1-cycle start-of-frame pulse
// LINE_VALID   in   1   high while a sensor line is arriving
// RD_REQ       in   1   downstream ready to take a line (level)
// BUFER_CHANGE out  1   bank select: 1 = write bank1/read bank2, 0 = write bank2/read bank1
// BUFER_IN_EN  out  1   write enable to buffer
// BUFER_OUT_EN out  1   read enable to buffer
// START_WRITE  out  1   1-cycle pulse restarting buffer read counter
// LINE_READY   out  1   read bank holds a complete, unread line (full flag)
// ROW_IDX      out  9   row index of line in read bank
// OVERFLOW     out  1   sticky: a line was dropped
// DROP_CNT     out  8   dropped-line count, saturating at 255
// BEHAVIOUR
// - Reset: all outputs 0; write FSM W_IDLE, read FSM R_IDLE; pixel counters 0.
// - LINE_VALID rise = sampled 1 this cycle, 0 previous cycle (registered edge detect).
// - Write FSM:
//   W_IDLE -> W_FILL on LINE_VALID rise; BUFER_IN_EN high from the next cycle (1-cycle latency;
//     upstream delays pixel data by 1 cycle).
//   W_FILL: BUFER_IN_EN=1 for exactly PIX_IN_ROW cycles, then -> W_DONE. LINE_VALID falling early
//     does not shorten the burst.
//   W_DONE: when LINE_READY=0, toggle BUFER_CHANGE, set LINE_READY=1, -> W_IDLE (one cycle).
//     Otherwise stay in W_DONE.
//   LINE_VALID rise while in W_FILL or W_DONE: line dropped. No enable; OVERFLOW<=1; DROP_CNT+1.
// - Read FSM:
//   R_IDLE -> R_START when LINE_READY=1 and RD_REQ=1.
//   R_START: START_WRITE=1 for one cycle, -> R_DRAIN.
//   R_DRAIN: BUFER_OUT_EN=1 for exactly PIX_IN_ROW cycles. On the last one, LINE_READY<=0, -> R_IDLE.
//     RD_REQ deasserting mid-drain is ignored.
// - Swap/drain same cycle: LINE_READY clears on the final drain cycle. W_DONE swaps the following cycle.
// - Reading never overlaps a swap, since LINE_READY=1 for the whole read. BUFER_CHANGE changes only in W_DONE.
// - ROW_IDX: incremented on each swap, wraps ROWS-1 -> 0. FRAME_SYNC sets an internal pending bit;
//   the next swap loads ROW_IDX=0 instead of incrementing. In-flight bursts are not aborted.
// - RESET mid-burst: enables drop immediately (async). Partial line discarded. Bank select returns to 0.
// CONFIGURATION
// - LBUF_CTRL_STATS_EN defined: DROP_CNT counter and ROW_IDX counter/FRAME_SYNC logic implemented.
// - LBUF_CTRL_STATS_EN undefined: DROP_CNT and ROW_IDX tied to 0, FRAME_SYNC ignored.
//   OVERFLOW and all sequencing unchanged.
// TESTING (bench uses PIX_IN_ROW=8, ROWS=4, LBUF_CTRL_STATS_EN defined)
// - Reset, then one line, RD_REQ=1: IN_EN high 8 cycles starting 1 cycle after LINE_VALID rise.
//   BUFER_CHANGE 0->1, LINE_READY=1. START_WRITE pulse. OUT_EN high 8 cycles. LINE_READY=0 after.
// - Two lines back-to-back, RD_REQ=1: second fill overlaps first drain. Second swap waits for
//   LINE_READY=0, BUFER_CHANGE ends at 0. No drop; OVERFLOW=0.
// - RD_REQ=0, three lines: line 2 fills then waits in W_DONE. Line 3 rise is dropped.
//   OVERFLOW=1, DROP_CNT=1, no IN_EN for line 3.
// - Five lines with FRAME_SYNC before line 1: ROW_IDX sequence 0,1,2,3,0. FRAME_SYNC mid-frame
//   forces 0 on the next swap.
// - Assert RESET during R_DRAIN cycle 4: OUT_EN, LINE_READY, BUFER_CHANGE, DROP_CNT all 0
//   immediately. Next line behaves as from power-up.
// - Build without LBUF_CTRL_STATS_EN, overflow scenario repeated: OVERFLOW=1, DROP_CNT=0, ROW_IDX=0.

Source files
------------

// File: rtl/line_buffer_ctrl.sv
// Ping-pong line buffer sequencer: one bank fills from the ADC while the other drains to readout.
// Latency: write enable 1 cycle after LINE_VALID rise; START_WRITE 1 cycle after LINE_READY&RD_REQ.
// Backpressure: a full read bank holds the write side in W_DONE; a line arriving then is dropped.
// Optional statistics (DROP_CNT, ROW_IDX, FRAME_SYNC handling) are built when LBUF_CTRL_STATS_EN is defined.

module line_buffer_ctrl #(
   parameter int PIX_IN_ROW = 640,
   parameter int ROWS       = 480
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       FRAME_SYNC,
   input  logic       LINE_VALID,
   input  logic       RD_REQ,
   output logic       BUFER_CHANGE,
   output logic       BUFER_IN_EN,
   output logic       BUFER_OUT_EN,
   output logic       START_WRITE,
   output logic       LINE_READY,
   output logic [8:0] ROW_IDX,
   output logic       OVERFLOW,
   output logic [7:0] DROP_CNT
);

   localparam int CW = (PIX_IN_ROW > 1) ? $clog2(PIX_IN_ROW) : 1;
   localparam logic [CW-1:0] LAST_PIX = CW'(PIX_IN_ROW - 1);

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DONE} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_START, R_DRAIN} r_state_t;

   w_state_t      w_state;
   r_state_t      r_state;
   logic [CW-1:0] wcnt;
   logic [CW-1:0] rcnt;
   logic          lv_q;
   logic          bank_sel;
   logic          in_en;
   logic          out_en;
   logic          start_wr;
   logic          line_rdy;
   logic          ovf;

   logic          lv_rise;
   logic          line_drop;
   logic          bank_swap;

   // A line arriving while the write side is busy or blocked cannot be stored
   assign lv_rise   = LINE_VALID & ~lv_q;
   assign line_drop = lv_rise & ((w_state == W_FILL) | (w_state == W_DONE));
   assign bank_swap = (w_state == W_DONE) & ~line_rdy;

   // Write and read sequencers share the full flag, so both live in one block:
   // the write side only sets it while clear, the read side only clears it while set.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         w_state  <= W_IDLE;
         r_state  <= R_IDLE;
         wcnt     <= '0;
         rcnt     <= '0;
         lv_q     <= 1'b0;
         bank_sel <= 1'b0;
         in_en    <= 1'b0;
         out_en   <= 1'b0;
         start_wr <= 1'b0;
         line_rdy <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         lv_q <= LINE_VALID;
         if (line_drop) begin
            ovf <= 1'b1;
         end

         case (w_state)
            W_IDLE: begin
               if (lv_rise) begin
                  wcnt    <= '0;
                  in_en   <= 1'b1;
                  w_state <= W_FILL;
               end
            end
            W_FILL: begin
               // Burst length is fixed; an early LINE_VALID fall does not cut it short
               if (wcnt == LAST_PIX) begin
                  in_en   <= 1'b0;
                  w_state <= W_DONE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            W_DONE: begin
               if (!line_rdy) begin
                  bank_sel <= ~bank_sel;
                  line_rdy <= 1'b1;
                  w_state  <= W_IDLE;
               end
            end
            default: begin
               in_en   <= 1'b0;
               w_state <= W_IDLE;
            end
         endcase

         case (r_state)
            R_IDLE: begin
               if (line_rdy && RD_REQ) begin
                  start_wr <= 1'b1;
                  r_state  <= R_START;
               end
            end
            R_START: begin
               start_wr <= 1'b0;
               out_en   <= 1'b1;
               rcnt     <= '0;
               r_state  <= R_DRAIN;
            end
            R_DRAIN: begin
               // Once started, the drain completes regardless of RD_REQ
               if (rcnt == LAST_PIX) begin
                  out_en   <= 1'b0;
                  line_rdy <= 1'b0;
                  r_state  <= R_IDLE;
               end else begin
                  rcnt <= rcnt + 1'b1;
               end
            end
            default: begin
               start_wr <= 1'b0;
               out_en   <= 1'b0;
               r_state  <= R_IDLE;
            end
         endcase
      end
   end

`ifdef LBUF_CTRL_STATS_EN
   logic [7:0] drop_cnt;
   logic [8:0] row_idx;
   logic       frame_pend;

   // Saturating count of dropped lines
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         drop_cnt <= '0;
      end else if (line_drop && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

   // Row index follows each bank swap; a frame sync makes the next swap restart at row 0
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         row_idx    <= '0;
         frame_pend <= 1'b0;
      end else begin
         if (FRAME_SYNC) begin
            frame_pend <= 1'b1;
         end
         if (bank_swap) begin
            if (frame_pend || FRAME_SYNC) begin
               row_idx    <= '0;
               frame_pend <= 1'b0;
            end else if (row_idx == 9'(ROWS - 1)) begin
               row_idx <= '0;
            end else begin
               row_idx <= row_idx + 1'b1;
            end
         end
      end
   end

   assign DROP_CNT = drop_cnt;
   assign ROW_IDX  = row_idx;
`else
   logic unused_frame_sync;

   assign unused_frame_sync = FRAME_SYNC | bank_swap;
   assign DROP_CNT          = '0;
   assign ROW_IDX           = '0;
`endif

   assign BUFER_CHANGE = bank_sel;
   assign BUFER_IN_EN  = in_en;
   assign BUFER_OUT_EN = out_en;
   assign START_WRITE  = start_wr;
   assign LINE_READY   = line_rdy;
   assign OVERFLOW     = ovf;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with PIX_IN_ROW=8, ROWS=4.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.

module tb_line_buffer_ctrl;

`ifdef LBUF_CTRL_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       fs;
   logic       lv;
   logic       rd;
   logic       chg;
   logic       in_en;
   logic       out_en;
   logic       sw;
   logic       rdy;
   logic [8:0] row;
   logic       ovf;
   logic [7:0] drop;

   int n_vec = 0;
   int n_bad = 0;

   // {lv, rd} stimulus; expected {in_en, out_en, chg, rdy, sw, ovf}
   typedef struct packed {
      logic       lv;
      logic       rd;
      logic [5:0] exp;
   } vec_t;

   vec_t tbl [21];

   line_buffer_ctrl #(.PIX_IN_ROW(8), .ROWS(4)) dut (
      .CLK          (clk),
      .RESET        (rst),
      .FRAME_SYNC   (fs),
      .LINE_VALID   (lv),
      .RD_REQ       (rd),
      .BUFER_CHANGE (chg),
      .BUFER_IN_EN  (in_en),
      .BUFER_OUT_EN (out_en),
      .START_WRITE  (sw),
      .LINE_READY   (rdy),
      .ROW_IDX      (row),
      .OVERFLOW     (ovf),
      .DROP_CNT     (drop)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      lv  = 1'b0;
      rd  = 1'b0;
      fs  = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   // Apply the first n table vectors; ovf_exp overrides the sticky overflow expectation
   task automatic run_table(input int n, input logic ovf_exp);
      logic [5:0] e;
      for (int i = 0; i < n; i++) begin
         lv = tbl[i].lv;
         rd = tbl[i].rd;
         tick();
         e    = tbl[i].exp;
         e[0] = ovf_exp;
         check($sformatf("vec%0d", i), {26'd0, in_en, out_en, chg, rdy, sw, ovf}, {26'd0, e});
      end
   endtask

   initial begin
      int in_cnt;
      int out_cnt;
      int late;
      int nsw;
      logic prev_chg;
      int rows_seen [7];
      int exp_rows [7] = '{0, 1, 2, 3, 0, 1, 0};

      // Single line from power-up, reader always ready
      for (int i = 0; i < 8; i++)   tbl[i] = '{1'b1, 1'b1, 6'b100000};
      tbl[8]  = '{1'b0, 1'b1, 6'b000000};
      tbl[9]  = '{1'b0, 1'b1, 6'b001100};
      tbl[10] = '{1'b0, 1'b1, 6'b001110};
      for (int i = 11; i < 19; i++) tbl[i] = '{1'b0, 1'b1, 6'b011100};
      tbl[19] = '{1'b0, 1'b1, 6'b001000};
      tbl[20] = '{1'b0, 1'b1, 6'b001000};

      rst = 1'b1;
      lv  = 1'b0;
      rd  = 1'b0;
      fs  = 1'b0;
      @(negedge clk);
      check("reset_outputs", {12'd0, chg, in_en, out_en, sw, rdy, row, ovf, drop}, 32'd0);
      do_reset();

      // One full fill, swap, drain
      run_table(21, 1'b0);
      check("one_line_row", {23'd0, row}, STATS);
      rd = 1'b0;

      // Two back-to-back lines: second fill overlaps first drain, second swap waits
      do_reset();
      rd = 1'b1;
      in_cnt = 0;
      out_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         lv = (c < 8) || (c >= 10 && c < 18);
         tick();
         if (in_en)  in_cnt++;
         if (out_en) out_cnt++;
         if (c == 19) check("b2b_wait_swap", {30'd0, chg, rdy}, 32'b10);
         if (c == 20) check("b2b_second_swap", {30'd0, chg, rdy}, 32'b01);
      end
      check("b2b_in_cycles", in_cnt, 16);
      check("b2b_out_cycles", out_cnt, 16);
      check("b2b_end_state", {29'd0, chg, rdy, ovf}, 32'd0);
      check("b2b_drop_cnt", {24'd0, drop}, 0);
      check("b2b_row", {23'd0, row}, 2 * STATS);

      // Reader stalled: line 2 parks in W_DONE, line 3 is dropped
      do_reset();
      in_cnt = 0;
      late = 0;
      for (int c = 0; c < 30; c++) begin
         lv = (c < 8) || (c >= 10 && c < 18) || (c >= 20 && c < 28);
         tick();
         if (in_en) in_cnt++;
         if (in_en && c >= 20) late++;
      end
      check("ovf_in_cycles", in_cnt, 16);
      check("ovf_dropped_no_en", late, 0);
      check("ovf_flag", {31'd0, ovf}, 1);
      check("ovf_drop_cnt", {24'd0, drop}, STATS);
      check("ovf_full_state", {30'd0, chg, rdy}, 32'b11);
      check("ovf_row", {23'd0, row}, STATS);
      rd = 1'b1;
      lv = 1'b0;
      repeat (40) tick();
      check("ovf_drained_state", {30'd0, chg, rdy}, 32'b00);
      check("ovf_sticky", {31'd0, ovf}, 1);
      check("ovf_row_after_drain", {23'd0, row}, 2 * STATS);

      // Reset during the 4th drain cycle clears everything without a clock edge
      run_table(15, 1'b1);
      rst = 1'b1;
      #1;
      check("arst_outputs", {12'd0, chg, in_en, out_en, sw, rdy, row, ovf, drop}, 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      run_table(21, 1'b0);
      check("arst_next_line_row", {23'd0, row}, STATS);

      // Row index sequencing with frame sync at start and mid-frame
      do_reset();
      rd = 1'b1;
      nsw = 0;
      prev_chg = chg;
      for (int k = 0; k < 7; k++) begin
         for (int off = 0; off < 24; off++) begin
            lv = (off < 8);
            fs = (k == 0 && off == 0) || (k == 5 && off == 20);
            tick();
            if (chg != prev_chg) begin
               if (nsw < 7) rows_seen[nsw] = int'(row);
               nsw++;
            end
            prev_chg = chg;
         end
      end
      fs = 1'b0;
      lv = 1'b0;
      check("rows_swap_count", nsw, 7);
      for (int k = 0; k < 7; k++) begin
         check($sformatf("row_seq%0d", k), rows_seen[k], exp_rows[k] * STATS);
      end
      check("rows_no_overflow", {31'd0, ovf}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
